// File: rtl/fft_power_capture.sv
// ============================================================================
// fft_power_capture
//
// Sits on the Avalon-ST source side of the FFT core. Every accepted complex
// bin is turned into a power word (re^2 + im^2) and written into a one-frame
// buffer. The block also tracks the strongest bin and checks that sop/eop
// framing agrees with the frame length the FFT reports. When a frame is
// complete it is held for a downstream reader, and the FFT is back-pressured
// until the reader releases the frame with frame_ack.
//
// Ports
//   clk            system clock, all logic on the rising edge
//   reset_n        synchronous active-low reset
//   source_valid   FFT output word valid
//   source_ready   word accepted when source_valid && source_ready
//   source_sop     first bin of a frame
//   source_eop     last bin of a frame
//   source_error   FFT error code, nonzero taints the frame
//   source_real    real part (signed)
//   source_imag    imaginary part (signed)
//   fftpts_out     frame length reported by the FFT, sampled on accepted sop
//   frame_done     one-cycle pulse when a frame is complete and held
//   frame_len      length of the held frame
//   peak_bin       index of the largest power in the held frame
//   peak_pwr       largest power in the held frame
//   err_flags      [0] length mismatch, [1] word without sop / sop mid-frame,
//                  [2] source_error seen
//   rd_addr        buffer read address
//   rd_data        power at rd_addr, one cycle after rd_addr
//   frame_ack      reader releases the held frame
// ============================================================================
module fft_power_capture #(
    parameter int DATA_W  = 25,
    parameter int ADDR_W  = 11,
    parameter int MAX_PTS = 1024,
    parameter int PWR_W   = 2*DATA_W+1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     source_valid,
    output logic                     source_ready,
    input  logic                     source_sop,
    input  logic                     source_eop,
    input  logic [1:0]               source_error,
    input  logic signed [DATA_W-1:0] source_real,
    input  logic signed [DATA_W-1:0] source_imag,
    input  logic [ADDR_W:0]          fftpts_out,
    output logic                     frame_done,
    output logic [ADDR_W:0]          frame_len,
    output logic [ADDR_W-1:0]        peak_bin,
    output logic [PWR_W-1:0]         peak_pwr,
    output logic [2:0]               err_flags,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic [PWR_W-1:0]         rd_data,
    input  logic                     frame_ack
);

    // Buffer index width; bins never exceed MAX_PTS-1, so the upper address
    // bits are only needed for the read-side range check.
    localparam int IDX_W = (MAX_PTS > 1) ? $clog2(MAX_PTS) : 1;
    localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(MAX_PTS);
    localparam logic [ADDR_W:0] ONE_LEN = (ADDR_W+1)'(1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;
    localparam logic [1:0] ST_HOLD    = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] bin_cnt;
    logic [ADDR_W:0]   len_q;

    // Decode of the word currently offered on the stream
    logic              accept;
    logic              take_word;
    logic              stray_word;
    logic [ADDR_W:0]   len_cur;
    logic [ADDR_W:0]   lim_cur;
    logic              len_bad;
    logic [ADDR_W-1:0] bin_idx;
    logic              at_limit;
    logic              last_word;
    logic [2:0]        err_base;
    logic [2:0]        err_next;

    // Power pipeline
    logic                     s1_valid;
    logic                     s1_first;
    logic signed [DATA_W-1:0] s1_re;
    logic signed [DATA_W-1:0] s1_im;
    logic [ADDR_W-1:0]        s1_bin;
    logic signed [2*DATA_W-1:0] re_ext;
    logic signed [2*DATA_W-1:0] im_ext;
    logic signed [2*DATA_W-1:0] re_sq;
    logic signed [2*DATA_W-1:0] im_sq;
    logic [PWR_W-1:0]         pwr_calc;
    logic                     s2_valid;
    logic                     s2_first;
    logic [PWR_W-1:0]         s2_pwr;
    logic [ADDR_W-1:0]        s2_bin;

    logic [PWR_W-1:0] buffer [MAX_PTS];

    // The stream is open only in IDLE and CAPTURE, and never while reset is
    // asserted, so nothing can slip in on a reset edge.
    assign source_ready = reset_n && ((state == ST_IDLE) || (state == ST_CAPTURE));

    // Classify the offered word. A sop always opens a frame (from IDLE, or as
    // a restart mid-frame), so length, bin index and limit come from the new
    // frame when sop is set. Out-of-range lengths are captured up to MAX_PTS
    // bins. A frame ends on eop or when the bin count reaches the limit; any
    // disagreement between the two is a length mismatch.
    always_comb begin
        accept     = source_valid && source_ready;
        take_word  = accept && ((state == ST_CAPTURE) || source_sop);
        stray_word = accept && (state == ST_IDLE) && !source_sop;
        len_cur    = source_sop ? fftpts_out : len_q;
        len_bad    = (len_cur == '0) || (len_cur > MAX_LEN);
        lim_cur    = len_bad ? MAX_LEN : len_cur;
        bin_idx    = source_sop ? '0 : bin_cnt;
        at_limit   = ({1'b0, bin_idx} == (lim_cur - ONE_LEN));
        last_word  = source_eop || at_limit;

        // Flags a new frame starts from: stray words seen in IDLE carry into
        // the frame they precede; a mid-frame restart keeps only the sop flag.
        if (!source_sop) begin
            err_base = err_flags;
        end else if (state == ST_CAPTURE) begin
            err_base = 3'b010;
        end else begin
            err_base = {1'b0, err_flags[1], 1'b0};
        end

        err_next = err_base | {(source_error != 2'b00), 1'b0,
                               (source_sop && len_bad) || (source_eop != at_limit)};
    end

    // Frame control FSM. frame_len and err_flags describe the frame being
    // captured and are stable once HOLD is reached. DRAIN waits for the last
    // word to leave stage 1; its stage-2 write lands on the same edge that
    // raises frame_done, so everything is final when the pulse is seen.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            bin_cnt    <= '0;
            len_q      <= '0;
            frame_len  <= '0;
            err_flags  <= '0;
            frame_done <= 1'b0;
            peak_bin   <= '0;
            peak_pwr   <= '0;
        end else begin
            frame_done <= 1'b0;

            case (state)
                ST_IDLE, ST_CAPTURE: begin
                    if (take_word) begin
                        if (source_sop) begin
                            len_q     <= fftpts_out;
                            frame_len <= fftpts_out;
                        end
                        err_flags <= err_next;
                        bin_cnt   <= bin_idx + ADDR_W'(1);
                        state     <= last_word ? ST_DRAIN : ST_CAPTURE;
                    end else if (stray_word) begin
                        err_flags[1] <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (!s1_valid) begin
                        state      <= ST_HOLD;
                        frame_done <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (frame_ack) begin
                        state     <= ST_IDLE;
                        err_flags <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Peak tracking rides on the stage-2 write. The first bin of a
            // frame overwrites whatever was there (this is the peak clear, kept
            // in order with any abandoned words still in flight); afterwards a
            // strictly larger power is needed, so ties keep the lowest bin.
            if (s2_valid) begin
                if (s2_first || (s2_pwr > peak_pwr)) begin
                    peak_pwr <= s2_pwr;
                    peak_bin <= s2_bin;
                end
            end
        end
    end

    // Pipeline valid bits, cleared by reset so an aborted frame leaves no
    // trace in the buffer or the peak registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            s1_valid <= take_word;
            s2_valid <= s1_valid;
        end
    end

    // Squares are taken on operands sign-extended to the full product width.
    // The true result is below 2^(2*DATA_W-1), so the truncated product is
    // exact and the sum of two squares fits PWR_W without saturation.
    assign re_ext   = {{DATA_W{s1_re[DATA_W-1]}}, s1_re};
    assign im_ext   = {{DATA_W{s1_im[DATA_W-1]}}, s1_im};
    assign re_sq    = re_ext * re_ext;
    assign im_sq    = im_ext * im_ext;
    assign pwr_calc = PWR_W'({1'b0, re_sq}) + PWR_W'({1'b0, im_sq});

    // Pipeline data registers: stage 1 holds the raw word, stage 2 the power.
    always_ff @(posedge clk) begin
        if (take_word) begin
            s1_re    <= source_real;
            s1_im    <= source_imag;
            s1_bin   <= bin_idx;
            s1_first <= source_sop;
        end
        if (s1_valid) begin
            s2_pwr   <= pwr_calc;
            s2_bin   <= s1_bin;
            s2_first <= s1_first;
        end
    end

    // Frame buffer write from stage 2.
    always_ff @(posedge clk) begin
        if (reset_n && s2_valid) begin
            buffer[s2_bin[IDX_W-1:0]] <= s2_pwr;
        end
    end

    // Registered read port; addresses beyond the buffer read as zero.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_data <= '0;
        end else if ({1'b0, rd_addr} < MAX_LEN) begin
            rd_data <= buffer[rd_addr[IDX_W-1:0]];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: tb/tb_fft_power_capture.sv
// ============================================================================
// tb_fft_power_capture
//
// Directed bench for fft_power_capture. Frames are driven on the falling edge
// and outputs sampled on the falling edge, half a cycle away from the rising
// edge the design uses. Expected powers, peaks and flags are worked out by
// hand from the vectors each step drives.
// ============================================================================
module tb_fft_power_capture;

    localparam int DATA_W  = 25;
    localparam int ADDR_W  = 11;
    localparam int MAX_PTS = 1024;
    localparam int PWR_W   = 2*DATA_W+1;

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic                     source_valid;
    logic                     source_ready;
    logic                     source_sop;
    logic                     source_eop;
    logic [1:0]               source_error;
    logic signed [DATA_W-1:0] source_real;
    logic signed [DATA_W-1:0] source_imag;
    logic [ADDR_W:0]          fftpts_out;
    logic                     frame_done;
    logic [ADDR_W:0]          frame_len;
    logic [ADDR_W-1:0]        peak_bin;
    logic [PWR_W-1:0]         peak_pwr;
    logic [2:0]               err_flags;
    logic [ADDR_W-1:0]        rd_addr;
    logic [PWR_W-1:0]         rd_data;
    logic                     frame_ack;

    int errors = 0;
    int checks = 0;
    logic [63:0] big_pwr;
    bit          done_seen;

    fft_power_capture #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .MAX_PTS(MAX_PTS),
        .PWR_W  (PWR_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .source_valid(source_valid),
        .source_ready(source_ready),
        .source_sop  (source_sop),
        .source_eop  (source_eop),
        .source_error(source_error),
        .source_real (source_real),
        .source_imag (source_imag),
        .fftpts_out  (fftpts_out),
        .frame_done  (frame_done),
        .frame_len   (frame_len),
        .peak_bin    (peak_bin),
        .peak_pwr    (peak_pwr),
        .err_flags   (err_flags),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .frame_ack   (frame_ack)
    );

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    // One comparison: counts it, and on a miss counts the failure and reports
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one stream word onto the source interface
    task automatic applyStimulus(input logic v, input logic s, input logic e,
                                 input logic [1:0] er, input int re, input int im);
        source_valid = v;
        source_sop   = s;
        source_eop   = e;
        source_error = er;
        source_real  = re[DATA_W-1:0];
        source_imag  = im[DATA_W-1:0];
    endtask

    // Send nwords bins; bin k carries re=k, im=-k (or -2^24 for both when big)
    task automatic runFrame(input int len_field, input int nwords, input int eop_bin,
                            input bit gaps, input int err_bin, input logic [1:0] err_code,
                            input bit big);
        int re;
        int im;
        fftpts_out = (ADDR_W+1)'(len_field);
        for (int k = 0; k < nwords; k++) begin
            re = big ? -(1 << (DATA_W-1)) : k;
            im = big ? -(1 << (DATA_W-1)) : -k;
            applyStimulus(1'b1, k == 0, k == eop_bin, (k == err_bin) ? err_code : 2'b00, re, im);
            @(negedge clk);
            if (gaps && (k != nwords - 1)) begin
                applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 0, 0);
                @(negedge clk);
            end
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 0, 0);
    endtask

    // Called one cycle after the frame's last word; bounded wait for the pulse
    task automatic waitDone(input int exp_lat);
        int lat;
        lat = 1;
        checkOutput("ready_in_drain", source_ready, 0);
        while (!frame_done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("done_latency", lat, exp_lat);
        @(negedge clk);
        checkOutput("done_pulse_width", frame_done, 0);
    endtask

    task automatic checkFrame(input int len, input int pbin, input logic [63:0] ppwr,
                              input logic [2:0] err);
        checkOutput("frame_len", frame_len, len);
        checkOutput("peak_bin", peak_bin, pbin);
        checkOutput("peak_pwr", peak_pwr, ppwr);
        checkOutput("err_flags", err_flags, err);
    endtask

    task automatic readBin(input int addr, input logic [63:0] expected);
        rd_addr = ADDR_W'(addr);
        @(negedge clk);
        checkOutput($sformatf("rd_data[%0d]", addr), rd_data, expected);
    endtask

    // Release the held frame; ready must stay low until the cycle after ack
    task automatic ackFrame();
        checkOutput("ready_in_hold", source_ready, 0);
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        checkOutput("ready_after_ack", source_ready, 1);
    endtask

    initial begin
        big_pwr    = 64'd1 << 49;
        reset_n    = 1'b0;
        frame_ack  = 1'b0;
        rd_addr    = '0;
        fftpts_out = '0;
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 0, 0);
        @(negedge clk);
        @(negedge clk);

        // Reset state
        checkOutput("reset_ready", source_ready, 0);
        checkOutput("reset_done", frame_done, 0);
        checkOutput("reset_rd_data", rd_data, 0);
        checkFrame(0, 0, 64'd0, 3'b000);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_release", source_ready, 1);

        // 8-point clean frame, continuous valid: power 2k^2
        $display("[TB] clean 8-point frame");
        runFrame(8, 8, 7, 1'b0, -1, 2'b00, 1'b0);
        waitDone(3);
        checkFrame(8, 7, 64'd98, 3'b000);
        for (int k = 0; k < 8; k++) readBin(k, 64'(2 * k * k));
        ackFrame();

        // Same frame with valid toggling
        $display("[TB] 8-point frame with gaps");
        runFrame(8, 8, 7, 1'b1, -1, 2'b00, 1'b0);
        waitDone(3);
        checkFrame(8, 7, 64'd98, 3'b000);
        readBin(3, 64'd18);
        readBin(6, 64'd72);
        ackFrame();

        // Early eop on bin 5
        $display("[TB] early eop");
        runFrame(8, 6, 5, 1'b0, -1, 2'b00, 1'b0);
        waitDone(3);
        checkFrame(8, 5, 64'd50, 3'b001);
        ackFrame();

        // No eop by bin 7: frame closes on the length limit
        $display("[TB] missing eop");
        runFrame(8, 8, -1, 1'b0, -1, 2'b00, 1'b0);
        waitDone(3);
        checkFrame(8, 7, 64'd98, 3'b001);
        ackFrame();

        // Three words without sop, then a 4-point frame with an error on bin 2
        $display("[TB] stray words and source_error");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 20 + k, 20 + k);
            @(negedge clk);
        end
        runFrame(4, 4, 3, 1'b0, 2, 2'b01, 1'b0);
        waitDone(3);
        checkFrame(4, 3, 64'd18, 3'b110);
        readBin(2, 64'd8);
        ackFrame();

        // Full-scale negative inputs: exact 2^49 and tie keeps bin 0
        $display("[TB] full-scale tie");
        runFrame(4, 4, 3, 1'b0, -1, 2'b00, 1'b1);
        waitDone(3);
        checkFrame(4, 0, big_pwr, 3'b000);
        readBin(3, big_pwr);
        ackFrame();

        // Reset for one cycle while bin 3 is offered
        $display("[TB] reset mid-frame");
        runFrame(8, 3, -1, 1'b0, -1, 2'b00, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 3, -3);
        reset_n = 1'b0;
        @(negedge clk);
        checkOutput("abort_ready", source_ready, 0);
        checkOutput("abort_rd_data", rd_data, 0);
        checkFrame(0, 0, 64'd0, 3'b000);
        reset_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 0, 0);
        done_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (frame_done) done_seen = 1'b1;
        end
        checkOutput("abort_no_done", done_seen, 0);
        checkOutput("abort_ready_back", source_ready, 1);

        // Clean frame after the aborted one
        $display("[TB] clean frame after reset");
        runFrame(8, 8, 7, 1'b0, -1, 2'b00, 1'b0);
        waitDone(3);
        checkFrame(8, 7, 64'd98, 3'b000);
        readBin(4, 64'd32);
        readBin(0, 64'd0);
        ackFrame();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
